decode_queue: RTL
=================

// Module: decode_queue
//
// PURPOSE
// - Parametrised, buffered instruction decoder for the SIMT core.
// - Accepts raw instructions on a valid/ready handshake and decodes them into a register-file/ALU/LSU/PC control bundle.
// - Holds decoded bundles in a DEPTH-entry FIFO so fetch and execute are decoupled.
// - Adds illegal-opcode detection, flush and an occupancy count.
//
// PARAMETERS
// - REG_AW   4   register-address field width; INSTR_W = 4 + 3*REG_AW (16 at default); IMM_W = 2*REG_AW
// - DEPTH    2   decoded-bundle FIFO entries, power of two, >= 2
// - CNT_W    $clog2(DEPTH+1)   occupancy width (derived, localparam)
//
// PORTS
// - clk          in   1         clock
// - reset        in   1         synchronous, active-high
// - flush        in   1         discard all queued bundles (branch redirect)
// - in_valid     in   1         instruction present
// - in_ready     out  1         queue can accept
// - instruction  in   INSTR_W   [INSTR_W-1 -: 4]=opcode, then rd, rs, rt fields of REG_AW bits each
// - out_valid    out  1         head bundle valid
// - out_ready    in   1         consumer takes head bundle
// - rd/rs/rt     out  REG_AW    decoded register addresses
// - imm          out  IMM_W     instruction[IMM_W-1:0]
// - nzp          out  3         top 3 bits of the rd field
// - reg_we, mem_re, mem_we, nzp_we, alu_out_mux, pc_mux, ret, barrier, illegal   out 1 each
// - reg_mux, alu_mux   out  2 each
// - count        out  CNT_W     entries held
//
// BEHAVIOUR
// Reset
// - Synchronous reset empties the FIFO: count=0, out_valid=0, in_ready=1.
// - Pointers reset to 0. Every bundle output reads 0.
//
// Handshake
// - push = in_valid & in_ready.
// - pop = out_valid & out_ready.
// - in_ready = (count < DEPTH), registered-state only, with no combinational path from out_ready.
// - out_valid = (count != 0).
//
// Latency
// - An instruction pushed in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
// - Decode is combinational on the input; the decoded bundle is stored.
//
// Decode per opcode. Fields not listed are 0; rd/rs/rt/imm/nzp are always extracted.
//
// | Opcode | Mnemonic | Decoded controls                            |
// |--------|----------|---------------------------------------------|
// | 0      | NOP      | no controls set                             |
// | 1      | BRNZP    | pc_mux=1                                    |
// | 2      | CMP      | alu_out_mux=1, nzp_we=1                     |
// | 3      | ADD      | reg_we=1, alu_mux=00                        |
// | 4      | SUB      | reg_we=1, alu_mux=01                        |
// | 5      | MUL      | reg_we=1, alu_mux=10                        |
// | 6      | DIV      | reg_we=1, alu_mux=11                        |
// | 7      | LDR      | reg_we=1, reg_mux=01, mem_re=1              |
// | 8      | STR      | mem_we=1                                    |
// | 9      | CONST    | reg_we=1, reg_mux=10                        |
// | A      | SYNC     | barrier=1                                   |
// | F      | RET      | ret=1                                       |
// | B-E    | (none)   | illegal=1, all other controls 0; still queued in order |
//
// Empty FIFO
// - When out_valid=0, all bundle outputs are forced to 0 so a downstream that ignores valid issues no writes.
//
// Boundary conditions
// - Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
// - Full (count=DEPTH): in_ready=0; a pop that cycle does not admit a same-cycle push.
// - Empty: a pop is impossible because out_valid=0, so count never underflows.
// - Pointers wrap modulo DEPTH.
// - flush has priority over push and pop: the next cycle has count=0 and pointers at 0, and the input that cycle is dropped.
// - reset has priority over flush. Reset mid-stream discards every entry.
//
// TESTING
// 1. Reset, then push 0x3123 (ADD) with out_ready=0.
//    - Next cycle: out_valid=1, rd=1, rs=2, rt=3, reg_we=1, alu_mux=00, count=1.
// 2. Push 0x7A40 (LDR) then 0x9C05 (CONST), out_ready=0.
//    - count=2, in_ready=0; a third push is stalled.
//    - Pop order: LDR with mem_re=1 and reg_mux=01, then CONST with imm=0x05 and reg_mux=10.
// 3. Push 0xB000 (illegal).
//    - Head shows illegal=1 with all enables 0; the following 0xF000 pops with ret=1.
// 4. Steady stream with in_valid=out_ready=1 at count=1.
//    - One bundle per cycle, count stays 1, order preserved across pointer wrap (>= 8 instructions).
// 5. Queue two entries, then assert flush together with in_valid.
//    - Next cycle: count=0, out_valid=0, all outputs 0, in_ready=1, flushed-cycle input lost.
// 6. Assert reset while full.
//    - Next cycle: count=0, out_valid=0, in_ready=1.
// 7. BRNZP 0x1E00.
//    - pc_mux=1, nzp=3'b111.

Source files
------------

// File: rtl/decode_queue_if.sv
// Decode-queue bus: fetch-side instruction handshake, flush, and the decoded
// head bundle presented to execute.
interface decode_queue_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned INSTR_W = 4 + 3 * REG_AW;
  localparam int unsigned IMM_W   = 2 * REG_AW;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [REG_AW-1:0]  rd;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [IMM_W-1:0]   imm;
  logic [2:0]         nzp;
  logic               reg_we;
  logic               mem_re;
  logic               mem_we;
  logic               nzp_we;
  logic               alu_out_mux;
  logic               pc_mux;
  logic               ret;
  logic               barrier;
  logic               illegal;
  logic [1:0]         reg_mux;
  logic [1:0]         alu_mux;
  logic [CNT_W-1:0]   count;

  // Fetch/execute side.
  modport master (
    output flush, in_valid, instruction, out_ready,
    input  in_ready, out_valid, rd, rs, rt, imm, nzp, reg_we, mem_re, mem_we, nzp_we,
           alu_out_mux, pc_mux, ret, barrier, illegal, reg_mux, alu_mux, count
  );

  // Decode queue side.
  modport slave (
    input  flush, in_valid, instruction, out_ready,
    output in_ready, out_valid, rd, rs, rt, imm, nzp, reg_we, mem_re, mem_we, nzp_we,
           alu_out_mux, pc_mux, ret, barrier, illegal, reg_mux, alu_mux, count
  );
endinterface

// File: rtl/decode_queue.sv
// Buffered instruction decoder: decodes on the way in, stores decoded bundles
// in a DEPTH-entry FIFO so fetch and execute are decoupled.
module decode_queue #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 2  // power of two, >= 2; REG_AW must be >= 3
) (
  input logic          clk,
  input logic          reset,
  decode_queue_if.slave bus
);
  localparam int unsigned INSTR_W = 4 + 3 * REG_AW;
  localparam int unsigned IMM_W   = 2 * REG_AW;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        nzp;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
    logic              nzp_we;
    logic              alu_out_mux;
    logic              pc_mux;
    logic              ret;
    logic              barrier;
    logic              illegal;
    logic [1:0]        reg_mux;
    logic [1:0]        alu_mux;
  } bundle_t;

  bundle_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;
  logic [3:0]       opcode;
  bundle_t          dec;
  bundle_t          head;

  // Handshake depends only on registered occupancy.
  assign bus.in_ready  = count_q < CNT_W'(DEPTH);
  assign bus.out_valid = count_q != '0;
  assign bus.count     = count_q;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign opcode        = bus.instruction[INSTR_W-1 -: 4];

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec     = '0;
    dec.rd  = bus.instruction[INSTR_W-5 -: REG_AW];
    dec.rs  = bus.instruction[INSTR_W-5-REG_AW -: REG_AW];
    dec.rt  = bus.instruction[REG_AW-1:0];
    dec.imm = bus.instruction[IMM_W-1:0];
    dec.nzp = dec.rd[REG_AW-1 -: 3];
    case (opcode)
      4'h0: begin end
      4'h1: dec.pc_mux = 1'b1;
      4'h2: begin
        dec.alu_out_mux = 1'b1;
        dec.nzp_we      = 1'b1;
      end
      4'h3: begin
        dec.reg_we  = 1'b1;
        dec.alu_mux = 2'b00;
      end
      4'h4: begin
        dec.reg_we  = 1'b1;
        dec.alu_mux = 2'b01;
      end
      4'h5: begin
        dec.reg_we  = 1'b1;
        dec.alu_mux = 2'b10;
      end
      4'h6: begin
        dec.reg_we  = 1'b1;
        dec.alu_mux = 2'b11;
      end
      4'h7: begin
        dec.reg_we  = 1'b1;
        dec.reg_mux = 2'b01;
        dec.mem_re  = 1'b1;
      end
      4'h8: dec.mem_we = 1'b1;
      4'h9: begin
        dec.reg_we  = 1'b1;
        dec.reg_mux = 2'b10;
      end
      4'hA: dec.barrier = 1'b1;
      4'hF: dec.ret     = 1'b1;
      // B-E are unassigned: flagged, but still queued in order.
      default: dec.illegal = 1'b1;
    endcase
  end

  // Bundle storage; contents need no reset because outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head bundle, forced to zero when empty so an ungated consumer issues nothing.
  always_comb begin
    head = '0;
    if (bus.out_valid) head = mem_q[rd_ptr_q];
  end

  assign bus.rd          = head.rd;
  assign bus.rs          = head.rs;
  assign bus.rt          = head.rt;
  assign bus.imm         = head.imm;
  assign bus.nzp         = head.nzp;
  assign bus.reg_we      = head.reg_we;
  assign bus.mem_re      = head.mem_re;
  assign bus.mem_we      = head.mem_we;
  assign bus.nzp_we      = head.nzp_we;
  assign bus.alu_out_mux = head.alu_out_mux;
  assign bus.pc_mux      = head.pc_mux;
  assign bus.ret         = head.ret;
  assign bus.barrier     = head.barrier;
  assign bus.illegal     = head.illegal;
  assign bus.reg_mux     = head.reg_mux;
  assign bus.alu_mux     = head.alu_mux;
endmodule
